// File: rtl/glyph_plotter.sv
// glyph_plotter: walks a built-in glyph bitmap and emits one screen pixel per
// plot handshake, with integer scaling and wrap-around screen coordinates.
// Optional build macro: GLYPH_PLOTTER_BG_EN (plot background positions in
// bg colour instead of skipping them as transparent).
module glyph_plotter #(
    parameter int unsigned CODE_W   = 4,
    parameter int unsigned GLYPH_W  = 16,
    parameter int unsigned GLYPH_H  = 16,
    parameter int unsigned SCALE    = 1,
    parameter int unsigned X_W      = 8,
    parameter int unsigned Y_W      = 7,
    parameter int unsigned COLOUR_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_valid,
    output logic                start_ready,
    input  logic [CODE_W-1:0]   char_code,
    input  logic [X_W-1:0]      origin_x,
    input  logic [Y_W-1:0]      origin_y,
    input  logic [COLOUR_W-1:0] fg_colour,
    input  logic [COLOUR_W-1:0] bg_colour,
    output logic [X_W-1:0]      plot_x,
    output logic [Y_W-1:0]      plot_y,
    output logic [COLOUR_W-1:0] plot_colour,
    output logic                plot_valid,
    input  logic                plot_ready,
    output logic                busy,
    output logic                done
);

    localparam int unsigned BITS  = GLYPH_W * GLYPH_H;
    localparam int unsigned IDX_W = (BITS > 1)    ? $clog2(BITS)    : 1;
    localparam int unsigned GC_W  = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
    localparam int unsigned GR_W  = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
    localparam int unsigned SC_W  = (SCALE > 1)   ? $clog2(SCALE)   : 1;

    // Label font, codes 1..12, rows 3..12; MSB of each row word is column 0.
    localparam logic [15:0] FONT [0:11][0:9] = '{
        '{16'h0FF0, 16'h0800, 16'h0800, 16'h0800, 16'h0F80, 16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'h0800}, // F
        '{16'h0FE0, 16'h0810, 16'h0810, 16'h0810, 16'h0FE0, 16'h0810, 16'h0810, 16'h0810, 16'h0810, 16'h0FE0}, // B
        '{16'h07F0, 16'h0800, 16'h0800, 16'h0800, 16'h07E0, 16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0FE0}, // S
        '{16'h07E0, 16'h0810, 16'h0010, 16'h0010, 16'h0020, 16'h0040, 16'h0080, 16'h0100, 16'h0200, 16'h0FF0}, // 2
        '{16'h0FE0, 16'h0010, 16'h0010, 16'h0010, 16'h03E0, 16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0FE0}, // 3
        '{16'h07E0, 16'h0810, 16'h0810, 16'h0810, 16'h07F0, 16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h07E0}, // 9
        '{16'h09F0, 16'h0910, 16'h0910, 16'h0910, 16'h0910, 16'h0910, 16'h0910, 16'h0910, 16'h0910, 16'h09F0}, // 10
        '{16'h0FE0, 16'h0810, 16'h0810, 16'h0810, 16'h0FE0, 16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'h0800}, // P
        '{16'h0180, 16'h0380, 16'h0180, 16'h0180, 16'h0180, 16'h0180, 16'h0180, 16'h0180, 16'h0180, 16'h03C0}, // 1
        '{16'h0810, 16'h0810, 16'h0810, 16'h0810, 16'h0810, 16'h0810, 16'h0990, 16'h0990, 16'h0A50, 16'h0C30}, // W
        '{16'h0380, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0380}, // I
        '{16'h0420, 16'h0620, 16'h0520, 16'h0520, 16'h04A0, 16'h04A0, 16'h0460, 16'h0460, 16'h0420, 16'h0420}  // N
    };

    typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;

    // Expand a code into the row-major glyph word (bit r*GLYPH_W + c).
    function automatic logic [BITS-1:0] glyph_word(input logic [CODE_W-1:0] code);
        logic [BITS-1:0] w;
        int unsigned     ci;
        w  = '0;
        ci = 32'(code);
        if (ci >= 1 && ci <= 12) begin
            for (int unsigned r = 3; r <= 12; r++) begin
                for (int unsigned c = 0; c < 16; c++) begin
                    if (r < GLYPH_H && c < GLYPH_W)
                        w[IDX_W'(r * GLYPH_W + c)] = FONT[4'(ci - 1)][4'(r - 3)][4'(15 - c)];
                end
            end
        end
        return w;
    endfunction

    state_t                state;
    logic [CODE_W-1:0]     code_q;
    logic [X_W-1:0]        ox_q;
    logic [Y_W-1:0]        oy_q;
    logic [COLOUR_W-1:0]   fg_q;
    logic [COLOUR_W-1:0]   bg_q;
    logic [BITS-1:0]       glyph_q;
    logic [BITS-1:0]       glyph_sel;
    logic [SC_W-1:0]       src, sry, n_src, n_sry;
    logic [GC_W-1:0]       gc, n_gc;
    logic [GR_W-1:0]       gr, n_gr;
    logic [IDX_W-1:0]      base, n_base, n_idx;
    logic [X_W-1:0]        n_px;
    logic [Y_W-1:0]        n_py;
    logic                  last;
    logic                  n_bit;
    logic                  advance;

    assign glyph_sel = glyph_word(code_q);

    // Next scan position: sub-column, glyph column, sub-row, glyph row.
    always_comb begin
        n_src  = src + 1'b1;
        n_gc   = gc;
        n_sry  = sry;
        n_gr   = gr;
        n_base = base;
        n_px   = plot_x + 1'b1;
        n_py   = plot_y;
        last   = 1'b0;
        if (src == SC_W'(SCALE - 1)) begin
            n_src = '0;
            if (gc == GC_W'(GLYPH_W - 1)) begin
                n_gc = '0;
                n_px = ox_q;
                n_py = plot_y + 1'b1;
                if (sry == SC_W'(SCALE - 1)) begin
                    n_sry  = '0;
                    n_gr   = gr + 1'b1;
                    n_base = base + IDX_W'(GLYPH_W);
                    last   = (gr == GR_W'(GLYPH_H - 1));
                end else begin
                    n_sry = sry + 1'b1;
                end
            end else begin
                n_gc = gc + 1'b1;
            end
        end
        n_idx   = n_base + IDX_W'(n_gc);
        n_bit   = glyph_q[n_idx];
        advance = !plot_valid || plot_ready;
    end

    // Control FSM with registered handshake and plot outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            start_ready <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            plot_valid  <= 1'b0;
            plot_x      <= '0;
            plot_y      <= '0;
            plot_colour <= '0;
            code_q      <= '0;
            ox_q        <= '0;
            oy_q        <= '0;
            fg_q        <= '0;
            bg_q        <= '0;
            glyph_q     <= '0;
            src         <= '0;
            sry         <= '0;
            gc          <= '0;
            gr          <= '0;
            base        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    start_ready <= 1'b1;
                    if (start_valid && start_ready) begin
                        code_q      <= char_code;
                        ox_q        <= origin_x;
                        oy_q        <= origin_y;
                        fg_q        <= fg_colour;
                        bg_q        <= bg_colour;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    glyph_q     <= glyph_sel;
                    src         <= '0;
                    sry         <= '0;
                    gc          <= '0;
                    gr          <= '0;
                    base        <= '0;
                    plot_x      <= ox_q;
                    plot_y      <= oy_q;
                    plot_colour <= glyph_sel[0] ? fg_q : bg_q;
`ifdef GLYPH_PLOTTER_BG_EN
                    plot_valid  <= 1'b1;
`else
                    plot_valid  <= glyph_sel[0];
`endif
                    state       <= DRAW;
                end
                DRAW: begin
                    if (advance) begin
                        if (last) begin
                            plot_valid <= 1'b0;
                            done       <= 1'b1;
                            state      <= DONE;
                        end else begin
                            src         <= n_src;
                            sry         <= n_sry;
                            gc          <= n_gc;
                            gr          <= n_gr;
                            base        <= n_base;
                            plot_x      <= n_px;
                            plot_y      <= n_py;
                            plot_colour <= n_bit ? fg_q : bg_q;
`ifdef GLYPH_PLOTTER_BG_EN
                            plot_valid  <= 1'b1;
`else
                            plot_valid  <= n_bit;
`endif
                        end
                    end
                end
                DONE: begin
                    busy        <= 1'b0;
                    start_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_glyph_plotter.sv
// tb_glyph_plotter: randomized self-checking bench for glyph_plotter against a
// pixel-list reference model built from the glyph rules.
module tb_glyph_plotter;

    localparam int GW = 16;
    localparam int GH = 16;
    localparam int SC = 1;
    localparam int NPOS = GW * GH * SC * SC;
`ifdef GLYPH_PLOTTER_BG_EN
    localparam bit BG_EN = 1'b1;
`else
    localparam bit BG_EN = 1'b0;
`endif

    localparam logic [15:0] TFONT [0:11][0:9] = '{
        '{16'h0FF0, 16'h0800, 16'h0800, 16'h0800, 16'h0F80, 16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'h0800},
        '{16'h0FE0, 16'h0810, 16'h0810, 16'h0810, 16'h0FE0, 16'h0810, 16'h0810, 16'h0810, 16'h0810, 16'h0FE0},
        '{16'h07F0, 16'h0800, 16'h0800, 16'h0800, 16'h07E0, 16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0FE0},
        '{16'h07E0, 16'h0810, 16'h0010, 16'h0010, 16'h0020, 16'h0040, 16'h0080, 16'h0100, 16'h0200, 16'h0FF0},
        '{16'h0FE0, 16'h0010, 16'h0010, 16'h0010, 16'h03E0, 16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0FE0},
        '{16'h07E0, 16'h0810, 16'h0810, 16'h0810, 16'h07F0, 16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h07E0},
        '{16'h09F0, 16'h0910, 16'h0910, 16'h0910, 16'h0910, 16'h0910, 16'h0910, 16'h0910, 16'h0910, 16'h09F0},
        '{16'h0FE0, 16'h0810, 16'h0810, 16'h0810, 16'h0FE0, 16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'h0800},
        '{16'h0180, 16'h0380, 16'h0180, 16'h0180, 16'h0180, 16'h0180, 16'h0180, 16'h0180, 16'h0180, 16'h03C0},
        '{16'h0810, 16'h0810, 16'h0810, 16'h0810, 16'h0810, 16'h0810, 16'h0990, 16'h0990, 16'h0A50, 16'h0C30},
        '{16'h0380, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0380},
        '{16'h0420, 16'h0620, 16'h0520, 16'h0520, 16'h04A0, 16'h04A0, 16'h0460, 16'h0460, 16'h0420, 16'h0420}
    };

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_valid;
    logic       start_ready;
    logic [3:0] char_code;
    logic [7:0] origin_x;
    logic [6:0] origin_y;
    logic [2:0] fg_colour;
    logic [2:0] bg_colour;
    logic [7:0] plot_x;
    logic [6:0] plot_y;
    logic [2:0] plot_colour;
    logic       plot_valid;
    logic       plot_ready;
    logic       busy;
    logic       done;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   acc_n = 0;
    int   acc_cyc = 0;
    int   done_n = 0;
    int   done_cyc = 0;
    int   stall_n = 0;
    pix_t cap_q[$];
    pix_t exp_q[$];

    glyph_plotter dut (
        .clk(clk), .reset(reset),
        .start_valid(start_valid), .start_ready(start_ready),
        .char_code(char_code), .origin_x(origin_x), .origin_y(origin_y),
        .fg_colour(fg_colour), .bg_colour(bg_colour),
        .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour),
        .plot_valid(plot_valid), .plot_ready(plot_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe handshakes mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (plot_valid && plot_ready) cap_q.push_back(pix_t'({plot_x, plot_y, plot_colour}));
            if (plot_valid && !plot_ready) stall_n = stall_n + 1;
            if (done) begin done_cyc = cyc; done_n = done_n + 1; end
            if (start_valid && start_ready) begin acc_cyc = cyc; acc_n = acc_n + 1; end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit font_bit(input int code, input int r, input int c);
        logic [15:0] row;
        if (code < 1 || code > 12 || r < 3 || r > 12 || c > 15) return 1'b0;
        row = TFONT[code-1][r-3];
        return row[15-c];
    endfunction

    // Reference: every screen position of the scaled glyph, row-major.
    task automatic build_expected(input int code, input int ox, input int oy, input int fg, input int bg);
        pix_t p;
        bit   b;
        exp_q.delete();
        for (int sy = 0; sy < GH * SC; sy++) begin
            for (int sx = 0; sx < GW * SC; sx++) begin
                b   = font_bit(code, sy / SC, sx / SC);
                p.x = 8'((ox + sx) % 256);
                p.y = 7'((oy + sy) % 128);
                p.c = b ? 3'(fg) : 3'(bg);
                if (b || BG_EN) exp_q.push_back(p);
            end
        end
    endtask

    function automatic int first_diff();
        int n;
        n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (cap_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic do_accept(input int code, input int ox, input int oy, input int fg, input int bg, output bit ok);
        int a0;
        a0 = acc_n;
        ok = 1'b0;
        stall_n = 0;
        char_code = 4'(code); origin_x = 8'(ox); origin_y = 7'(oy);
        fg_colour = 3'(fg); bg_colour = 3'(bg);
        start_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            if (acc_n != a0) begin ok = 1'b1; break; end
        end
        #1;
        start_valid = 1'b0;
        char_code = 4'($urandom); origin_x = 8'($urandom); origin_y = 7'($urandom);
        fg_colour = 3'($urandom); bg_colour = 3'($urandom);
    endtask

    task automatic wait_done(input int stall_pct, output bit ok);
        int d0;
        d0 = done_n;
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            plot_ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(99) >= stall_pct);
            @(posedge clk); #1;
            if (done_n != d0) begin ok = 1'b1; break; end
        end
        plot_ready = 1'b1;
    endtask

    task automatic run_draw(input int code, input int ox, input int oy, input int fg, input int bg,
                            input int stall_pct, output bit ok);
        bit a;
        cap_q.delete();
        build_expected(code, ox, oy, fg, bg);
        do_accept(code, ox, oy, fg, bg, a);
        ok = a;
        if (a) begin wait_done(stall_pct, ok); end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (plot_x !== 8'd0) begin bad++; $display("FAIL reset plot_x got %0d want 0", plot_x); end
        total++; if (plot_y !== 7'd0) begin bad++; $display("FAIL reset plot_y got %0d want 0", plot_y); end
        total++; if (plot_colour !== 3'd0) begin bad++; $display("FAIL reset plot_colour got %0d want 0", plot_colour); end
        total++; if (plot_valid !== 1'b0) begin bad++; $display("FAIL reset plot_valid got %b want 0", plot_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset done got %b want 0", done); end
        total++; if (start_ready !== 1'b0) begin bad++; $display("FAIL reset start_ready got %b want 0", start_ready); end
        reset = 1'b0;
        @(posedge clk); #1;
        total++; if (start_ready !== 1'b1) begin bad++; $display("FAIL release start_ready got %b want 1", start_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL release busy got %b want 0", busy); end
    endtask

    task automatic test_glyph_i();
        bit ok;
        int d, nfg, fx, fy;
        run_draw(11, 10, 20, 6, 1, 0, ok);
        total++; if (!ok) begin bad++; $display("FAIL glyph_i timeout got ok=%b want 1", ok); end
        total++; if (done_cyc - acc_cyc != 2 + NPOS) begin bad++; $display("FAIL glyph_i latency got %0d want %0d", done_cyc - acc_cyc, 2 + NPOS); end
        nfg = 0; fx = -1; fy = -1;
        foreach (cap_q[i]) if (cap_q[i].c == 3'd6) begin
            if (nfg == 0) begin fx = cap_q[i].x; fy = cap_q[i].y; end
            nfg++;
        end
        total++; if (fx != 16 || fy != 23) begin bad++; $display("FAIL glyph_i first_fg got (%0d,%0d) want (16,23)", fx, fy); end
        total++; if (nfg != 14) begin bad++; $display("FAIL glyph_i fg_count got %0d want 14", nfg); end
        total++; if (cap_q.size() != exp_q.size()) begin bad++; $display("FAIL glyph_i count got %0d want %0d", cap_q.size(), exp_q.size()); end
        d = first_diff();
        total++; if (d >= 0) begin bad++; $display("FAIL glyph_i plot[%0d] got %h want %h", d, cap_q[d], exp_q[d]); end
    endtask

    task automatic test_blank();
        bit ok;
        int d, nbg;
        run_draw(0, 0, 0, 6, 1, 0, ok);
        total++; if (!ok) begin bad++; $display("FAIL blank timeout got ok=%b want 1", ok); end
        total++; if (done_cyc - acc_cyc != 2 + NPOS) begin bad++; $display("FAIL blank latency got %0d want %0d", done_cyc - acc_cyc, 2 + NPOS); end
        nbg = 0;
        foreach (cap_q[i]) if (cap_q[i].c == 3'd1) nbg++;
        total++; if (nbg != cap_q.size()) begin bad++; $display("FAIL blank colour got %0d bg of %0d want all bg", nbg, cap_q.size()); end
        total++; if (cap_q.size() != exp_q.size()) begin bad++; $display("FAIL blank count got %0d want %0d", cap_q.size(), exp_q.size()); end
        d = first_diff();
        total++; if (d >= 0) begin bad++; $display("FAIL blank plot[%0d] got %h want %h", d, cap_q[d], exp_q[d]); end
    endtask

    task automatic test_backpressure();
        bit   ok, seen;
        int   d;
        pix_t want;
        cap_q.delete();
        build_expected(11, 10, 20, 6, 1);
        want = exp_q[0];
        do_accept(11, 10, 20, 6, 1, ok);
        plot_ready = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (plot_valid) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        total++; if (!ok || !seen) begin bad++; $display("FAIL backpressure first_plot got accept=%b seen=%b want 1 1", ok, seen); end
        for (int s = 0; s < 5; s++) begin
            total++;
            if ({plot_valid, plot_x, plot_y, plot_colour} !== {1'b1, want.x, want.y, want.c}) begin
                bad++;
                $display("FAIL backpressure hold[%0d] got v=%b (%0d,%0d,%0d) want v=1 (%0d,%0d,%0d)",
                         s, plot_valid, plot_x, plot_y, plot_colour, want.x, want.y, want.c);
            end
            @(posedge clk); #1;
        end
        wait_done(0, ok);
        total++; if (!ok) begin bad++; $display("FAIL backpressure timeout got ok=%b want 1", ok); end
        total++; if (done_cyc - acc_cyc != 2 + NPOS + 5) begin bad++; $display("FAIL backpressure latency got %0d want %0d", done_cyc - acc_cyc, 2 + NPOS + 5); end
        d = first_diff();
        total++; if (d >= 0 || cap_q.size() != exp_q.size()) begin bad++; $display("FAIL backpressure list idx=%0d got n=%0d want n=%0d", d, cap_q.size(), exp_q.size()); end
    endtask

    task automatic test_wrap();
        bit ok;
        int d;
        int xs[$];
        run_draw(12, 250, 0, 2, 5, 0, ok);
        total++; if (!ok) begin bad++; $display("FAIL wrap timeout got ok=%b want 1", ok); end
        foreach (cap_q[i]) if (cap_q[i].y == 7'd3 && cap_q[i].c == 3'd2) xs.push_back(int'(cap_q[i].x));
        total++; if (xs.size() != 2) begin bad++; $display("FAIL wrap row3_count got %0d want 2", xs.size()); end
        else begin
            total++; if (xs[0] != 255 || xs[1] != 4) begin bad++; $display("FAIL wrap row3_x got %0d,%0d want 255,4", xs[0], xs[1]); end
        end
        d = first_diff();
        total++; if (d >= 0 || cap_q.size() != exp_q.size()) begin bad++; $display("FAIL wrap list idx=%0d got n=%0d want n=%0d", d, cap_q.size(), exp_q.size()); end
    endtask

    task automatic test_random();
        bit ok;
        int d, code, ox, oy, fg, bg;
        for (int it = 0; it < 6; it++) begin
            code = $urandom_range(15); ox = $urandom_range(255); oy = $urandom_range(127);
            fg = $urandom_range(7); bg = $urandom_range(7);
            run_draw(code, ox, oy, fg, bg, 30, ok);
            total++; if (!ok) begin bad++; $display("FAIL random[%0d] timeout got ok=%b want 1", it, ok); end
            total++; if (done_cyc - acc_cyc - stall_n != 2 + NPOS) begin bad++; $display("FAIL random[%0d] latency got %0d want %0d", it, done_cyc - acc_cyc - stall_n, 2 + NPOS); end
            total++; if (cap_q.size() != exp_q.size()) begin bad++; $display("FAIL random[%0d] count got %0d want %0d", it, cap_q.size(), exp_q.size()); end
            d = first_diff();
            total++; if (d >= 0) begin bad++; $display("FAIL random[%0d] plot[%0d] got %h want %h", it, d, cap_q[d], exp_q[d]); end
        end
    endtask

    task automatic test_back_to_back();
        int a0, d0, first_done;
        bit got;
        a0 = acc_n; d0 = done_n;
        char_code = 4'd1; origin_x = 8'd40; origin_y = 7'd30; fg_colour = 3'd7; bg_colour = 3'd0;
        start_valid = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(posedge clk);
            if (done_n != d0) begin got = 1'b1; break; end
        end
        total++; if (!got || acc_n != a0 + 1) begin bad++; $display("FAIL b2b first got done=%b accepts=%0d want 1 %0d", got, acc_n - a0, 1); end
        first_done = done_cyc;
        @(posedge clk); #1;
        start_valid = 1'b0;
        total++; if (acc_n != a0 + 2) begin bad++; $display("FAIL b2b second_accept got %0d accepts want 2", acc_n - a0); end
        total++; if (acc_cyc != first_done + 1) begin bad++; $display("FAIL b2b accept_cycle got %0d want %0d", acc_cyc, first_done + 1); end
        wait_done(0, got);
        total++; if (!got || done_cyc - acc_cyc != 2 + NPOS) begin bad++; $display("FAIL b2b second_latency got %0d want %0d", done_cyc - acc_cyc, 2 + NPOS); end
    endtask

    task automatic test_reset_mid_draw();
        bit ok;
        int d0;
        do_accept(11, 100, 50, 3, 4, ok);
        d0 = done_n;
        repeat (101) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total++; if (plot_valid !== 1'b0) begin bad++; $display("FAIL midreset plot_valid got %b want 0", plot_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset busy got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL midreset done got %b want 0", done); end
        @(posedge clk); #1;
        total++; if (start_ready !== 1'b1) begin bad++; $display("FAIL midreset start_ready got %b want 1", start_ready); end
        repeat (300) @(posedge clk);
        #1;
        total++; if (done_n != d0) begin bad++; $display("FAIL midreset done_seen got %0d pulses want 0", done_n - d0); end
    endtask

    initial begin
        reset = 1'b1; start_valid = 1'b0; char_code = '0; origin_x = '0; origin_y = '0;
        fg_colour = '0; bg_colour = '0; plot_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_glyph_i();
        test_blank();
        test_backpressure();
        test_wrap();
        test_random();
        test_back_to_back();
        test_reset_mid_draw();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/glyph_plotter.md
# glyph_plotter

Sequential glyph renderer for the board display. Accepts a character code, screen origin and colours through a valid/ready handshake, then walks the glyph bitmap and emits one screen pixel per handshake to the VGA plot interface. Glyph size, integer scale factor and coordinate widths are parameters. It sits between the board/piece-drawing control FSM and the VGA adapter's plot port.

## Interface

Parameters:
- `CODE_W`, 4, width of the character code.
- `GLYPH_W`, 16, glyph columns.
- `GLYPH_H`, 16, glyph rows.
- `SCALE`, 1, integer pixel replication factor, 1..4; each glyph bit draws a SCALE×SCALE block.
- `X_W`, 8, screen x width.
- `Y_W`, 7, screen y width.
- `COLOUR_W`, 3, colour width.

Ports:
- `clk` in 1 — single clock; all logic on the rising edge.
- `reset` in 1 — synchronous, active-high.
- `start_valid` in 1 — draw request.
- `start_ready` out 1 — high only in IDLE.
- `char_code` in CODE_W — glyph select.
- `origin_x` in X_W, `origin_y` in Y_W — top-left screen pixel.
- `fg_colour` in COLOUR_W, `bg_colour` in COLOUR_W.
- `plot_x` out X_W, `plot_y` out Y_W, `plot_colour` out COLOUR_W — pixel to plot.
- `plot_valid` out 1, `plot_ready` in 1 — pixel handshake.
- `busy` out 1 — high in LOAD/DRAW/DONE.
- `done` out 1 — one-cycle pulse at the end of a glyph.

## Operation

- Internal glyph table, GLYPH_H·GLYPH_W bits per code. Codes 1..12 are the standard label set: F, B, S, 2, 3, 9, 10, P, 1, W, I, N. Rows 3..12 are populated; all other codes are blank.
- Bit addressing: pixel (row r, col c) = bit `r*GLYPH_W + c`. Row 0 is the top row, col 0 is the leftmost column.
- FSM states: IDLE → LOAD → DRAW → DONE → IDLE.
- IDLE: `start_ready`=1. When `start_valid`&&`start_ready`, latch code, origin and colours, then go to LOAD. Input changes after acceptance are ignored.
- LOAD: register the selected glyph word, clear the scan counters, go to DRAW.
- DRAW: row-major sweep of sy = 0..GLYPH_H·SCALE−1 (outer) and sx = 0..GLYPH_W·SCALE−1 (inner). Glyph index is (sy/SCALE, sx/SCALE), implemented with sub-counters; no dividers.
- `plot_x` = origin_x+sx mod 2^X_W; `plot_y` = origin_y+sy mod 2^Y_W. Off-screen positions wrap and are never clipped.
- Foreground position (bit = 1): `plot_valid`=1 with `plot_colour`=fg. The position advances only on `plot_valid`&&`plot_ready`. Outputs stay stable while stalled.
- Background position: see Configuration.
- After the last position has been consumed, go to DONE. DONE asserts `done` for one cycle, then returns to IDLE.
- Reset in any state, including mid-DRAW: next cycle is IDLE, no `done`, partial glyph abandoned.

## Timing

- Reset values: `start_ready`=0 while `reset` is high, 1 in the first cycle after release. `plot_x`, `plot_y`, `plot_colour`, `plot_valid`, `busy`, `done` = 0.
- Accept in cycle T → LOAD at T+1 → first DRAW position at T+2.
- With `plot_ready` held high, DRAW takes exactly GLYPH_H·GLYPH_W·SCALE² cycles and `done` = T+2+that count. Each stalled cycle adds one.
- Earliest next accept is the cycle after `done`. A `start_valid` asserted while busy is ignored, not queued.
- All outputs are registered; no combinational path from `plot_ready` or `start_valid` to any output.

## Configuration

- `GLYPH_PLOTTER_BG_EN` defined: background positions are plotted with `plot_colour`=bg and obey the same handshake. Every position produces one plot.
- Undefined: background positions hold `plot_valid`=0 for exactly one cycle and advance unconditionally (transparent). Total cycle count is identical to the defined case when `plot_ready` is always high.

## Test plan

- Reset: hold `reset` 2 cycles mid-idle → all outputs 0. After release, `start_ready`=1 and `busy`=0.
- BG_EN off, SCALE=1, code 11 ('I'), origin (10,20), `plot_ready`=1:
  - first plot at (16,23);
  - exactly 14 plots, all colour fg;
  - accept at T gives `done` at T+258.
- BG_EN on, code 0, origin (0,0), bg=3'b001 → 256 plots, all colour 1, ordered (0,0),(1,0)…(15,15); `done` at T+258.
- Backpressure: BG_EN on, drop `plot_ready` for 5 cycles on the first plot → plot (x,y,colour) held constant, `done` at T+263.
- Wrap: SCALE=1, X_W=8, code 12 ('N'), origin (250,0) → row 3 plots at x=255 and x=4 (260 mod 256), y=3.
- Reset mid-DRAW after 100 DRAW cycles → next cycle `plot_valid`=0, `busy`=0, `start_ready`=1, `done` never asserted.
